// File: rtl/logic_arbiter_if.sv
// logic_arbiter_if: bundles the request, logic-unit and response signals of
// logic_arbiter. The "slave" modport is the arbiter's own view; "master" is the
// view of the surrounding environment (requesters, logic unit, consumer).
//
// Handshake semantics, both on the request side (req_valid[i]/req_ready[i]) and
// on the response side (rsp_valid/rsp_ready): a transfer happens on a rising
// clk edge where valid and ready are both high. Once valid is raised, the
// source holds valid and its payload unchanged until that transfer. Ready may
// depend combinationally on valid, and valid never depends on ready.
interface logic_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 64
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_ctrl;
    logic [W*NREQ-1:0] req_op1;
    logic [W*NREQ-1:0] req_op2;

    logic [1:0]        lu_ctrl;
    logic [W-1:0]      lu_op1;
    logic [W-1:0]      lu_op2;
    logic [W-1:0]      lu_dst;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;

    logic              busy;
    logic [1:0]        dbg_state;

    modport slave (
        input  req_valid, req_ctrl, req_op1, req_op2, lu_dst, rsp_ready,
        output req_ready, lu_ctrl, lu_op1, lu_op2,
        output rsp_valid, rsp_id, rsp_data, busy, dbg_state
    );

    modport master (
        output req_valid, req_ctrl, req_op1, req_op2, lu_dst, rsp_ready,
        input  req_ready, lu_ctrl, lu_op1, lu_op2,
        input  rsp_valid, rsp_id, rsp_data, busy, dbg_state
    );
endinterface

// File: rtl/logic_arbiter.sv
// logic_arbiter: shares one registered logic unit (NOT/AND/OR/XOR, one cycle
// of latency) between NREQ requesters. One operation is in flight at a time:
// IDLE accepts -> ISSUE drives the unit -> WAIT captures dst -> RESP returns
// the result with the requester ID.
// Build option: define LOGIC_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer); default is round-robin.
module logic_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    logic_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_id;
    logic [1:0]      r_lu_ctrl;
    logic [W-1:0]    r_lu_op1;
    logic [W-1:0]    r_lu_op2;
    logic [W-1:0]    r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;
    logic            r_rsp_valid;
    logic            r_busy;

    logic            w_any;
    logic [IDW-1:0]  w_grant;
    logic [NREQ-1:0] w_grant_oh;
    logic            w_accept;
    logic [1:0]      w_sel_ctrl;
    logic [W-1:0]    w_sel_op1;
    logic [W-1:0]    w_sel_op2;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
    // Candidate index is one bit wider so last+k (at most 2*NREQ-1) never overflows.
    typedef logic [IDW:0] cand_t;

    logic [IDW-1:0]  r_last;
    cand_t           w_cand;

    // Round-robin winner: first valid requester after r_last, wrapping at NREQ.
    // The loop walks from lowest to highest priority so the last hit wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = cand_t'(r_last) + cand_t'(k);
            if (w_cand >= cand_t'(NREQ)) begin
                w_cand = w_cand - cand_t'(NREQ);
            end
            if (bus.req_valid[w_cand[IDW-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_cand[IDW-1:0];
            end
        end
    end
`else
    // Fixed-priority winner: lowest valid index, found by scanning downwards.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_any   = 1'b1;
                w_grant = IDW'(i);
            end
        end
    end
`endif

    // Route the winner's payload towards the unit operand registers.
    always_comb begin
        w_sel_ctrl = '0;
        w_sel_op1  = '0;
        w_sel_op2  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_ctrl = bus.req_ctrl[2*i +: 2];
                w_sel_op1  = bus.req_op1[W*i +: W];
                w_sel_op2  = bus.req_op2[W*i +: W];
            end
        end
    end

    assign w_grant_oh = NREQ'(1) << w_grant;
    assign w_accept   = (r_state == S_IDLE) && w_any;

    // Ready is only offered from IDLE, and is forced low while reset is held.
    assign bus.req_ready = (rst_n && w_accept) ? w_grant_oh : '0;

    // Sequencer: accept, let the unit register dst, capture it, then hold the
    // response until the consumer takes it. Operands change only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_lu_ctrl   <= '0;
            r_lu_op1    <= '0;
            r_lu_op2    <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
            r_last      <= IDW'(NREQ - 1);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lu_ctrl <= w_sel_ctrl;
                        r_lu_op1  <= w_sel_op1;
                        r_lu_op2  <= w_sel_op2;
                        r_id      <= w_grant;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
                        r_last    <= w_grant;
`endif
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_rsp_data  <= bus.lu_dst;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lu_ctrl   = r_lu_ctrl;
    assign bus.lu_op1    = r_lu_op1;
    assign bus.lu_op2    = r_lu_op2;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_logic_arbiter.sv
// tb_logic_arbiter: drives logic_arbiter with directed and random traffic and
// predicts every grant, response timing and result from a transaction-level
// model of the arbitration rules plus a model of the logic unit.
module tb_logic_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .W(W)) bus();

    logic_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Logic unit: ctrl 00 NOT op1, 01 AND, 10 OR, 11 XOR.
    function automatic logic [W-1:0] lu_func(input logic [1:0] c,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (c)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Registered logic unit instance shared with the arbiter.
    always @(posedge clk) bus.lu_dst <= lu_func(bus.lu_ctrl, bus.lu_op1, bus.lu_op2);

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit           pend  [NREQ];
    logic [1:0]   p_ctrl[NREQ];
    logic [W-1:0] p_op1 [NREQ];
    logic [W-1:0] p_op2 [NREQ];
    bit keep_all  = 1'b0;
    bit rand_post = 1'b0;
    int rdy_mode  = 1;   // 0: rsp_ready low, 1: high, 2: random

    // Transaction model: idle flag, round-robin pointer, accept cycle.
    bit m_idle  = 1'b1;
    int m_last  = NREQ - 1;
    int acc_cyc = 0;

    logic [W-1:0]   exp_q[$];
    logic [IDW-1:0] exp_id_q[$];

    // Observations taken from the DUT, checked against constants later.
    int             grant_log[$];
    int             acc_log[$];
    int             last_acc_cyc = -100;
    int             last_hs_cyc  = -100;
    logic [W-1:0]   last_data;
    logic [IDW-1:0] last_id;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Arbitration rule: first valid after the last winner (or lowest index
    // when fixed priority is built in).
    function automatic int model_pick(input logic [NREQ-1:0] v);
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (v[c]) return c;
        end
`endif
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic post_req(input int i, input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[i]   = 1'b1;
        p_ctrl[i] = c;
        p_op1[i]  = a;
        p_op2[i]  = b;
    endtask

    task automatic post_rand(input int i);
        post_req(i, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later, check
    // against the model and advance the model past the next rising edge.
    task automatic step();
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp_rdy;
        bit              exp_rv;
        int              w;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && (keep_all || (rand_post && $urandom_range(0, 2) == 0))) post_rand(i);
            v[i] = pend[i];
            bus.req_ctrl[2*i +: 2] = p_ctrl[i];
            bus.req_op1[W*i +: W]  = p_op1[i];
            bus.req_op2[W*i +: W]  = p_op2[i];
        end
        bus.req_valid = v;
        case (rdy_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        cyc++;

        check("busy", W'(bus.busy), W'(!m_idle));
        exp_rv = !m_idle && (cyc - acc_cyc >= 3);
        check("rsp_valid", W'(bus.rsp_valid), W'(exp_rv));
        if (exp_rv && exp_q.size() > 0) begin
            check("rsp_id", W'(bus.rsp_id), W'(exp_id_q[0]));
            check("rsp_data", bus.rsp_data, exp_q[0]);
        end
        w       = (m_idle && (v != '0)) ? model_pick(v) : -1;
        exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
        check("req_ready", W'(bus.req_ready), W'(exp_rdy));

        // DUT observations
        if ((bus.req_ready & v) != '0) begin
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grant_log.push_back(i);
            acc_log.push_back(cyc);
            last_acc_cyc = cyc;
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            last_data   = bus.rsp_data;
            last_id     = bus.rsp_id;
            last_hs_cyc = cyc;
        end

        // model advance
        if (w >= 0) begin
            exp_q.push_back(lu_func(p_ctrl[w], p_op1[w], p_op2[w]));
            exp_id_q.push_back(IDW'(w));
            pend[w] = 1'b0;
            m_idle  = 1'b0;
            acc_cyc = cyc;
            m_last  = w;
        end else if (exp_rv && bus.rsp_ready) begin
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(exp_id_q.pop_front());
            end
            m_idle = 1'b1;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!(m_idle && exp_q.size() == 0 && !any_pend()) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", W'(n < budget), W'(1));
    endtask

    // Reset pulse with all requesters valid, checking the reset-time outputs.
    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '1;
        #1;
        check("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
        check("rst_rsp_id",    W'(bus.rsp_id),    W'(0));
        check("rst_rsp_data",  bus.rsp_data,      W'(0));
        check("rst_lu_ctrl",   W'(bus.lu_ctrl),   W'(0));
        check("rst_lu_op1",    bus.lu_op1,        W'(0));
        check("rst_lu_op2",    bus.lu_op2,        W'(0));
        check("rst_req_ready", W'(bus.req_ready), W'(0));
        check("rst_busy",      W'(bus.busy),      W'(0));
        repeat (2) @(negedge clk);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        bus.req_valid = '0;
        exp_q.delete();
        exp_id_q.delete();
        m_idle = 1'b1;
        m_last = NREQ - 1;
        rst_n  = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] op_tbl[4];
        int           exp_order[5];
        int           n0;
        int           na;
        int           n;

        op_tbl[0] = 64'h5555_5555_5555_5555;
        op_tbl[1] = 64'h0000_0000_AAAA_AAAA;
        op_tbl[2] = 64'hAAAA_AAAA_FFFF_FFFF;
        op_tbl[3] = 64'hAAAA_AAAA_5555_5555;
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif

        bus.req_valid = '0;
        bus.req_ctrl  = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]   = 1'b0;
            p_ctrl[i] = '0;
            p_op1[i]  = '0;
            p_op2[i]  = '0;
        end

        // Power-on reset, then a lone request from requester 0.
        do_reset();
        rdy_mode = 1;
        n0 = grant_log.size();
        post_rand(0);
        run_until_idle(20);
        if (grant_log.size() > n0) check("first_grant", W'(grant_log[n0]), W'(0));
        else check("first_grant_seen", W'(0), W'(1));

        // Single XOR op from requester 2, latency 3.
        post_req(2, 2'b11, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F);
        run_until_idle(20);
        check("single_id",   W'(last_id), W'(2));
        check("single_data", last_data,   64'hF00F_F00F_F00F_F00F);
        check("single_lat",  W'(last_hs_cyc - last_acc_cyc), W'(3));

        // All four opcodes from requester 0.
        for (int c = 0; c < 4; c++) begin
            post_req(0, 2'(c), 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_0000_FFFF_FFFF);
            run_until_idle(20);
            check($sformatf("opcode%0d_data", c), last_data, op_tbl[c]);
        end

        // All requesters held valid: grant order and 4-cycle spacing.
        do_reset();
        n0 = grant_log.size();
        keep_all = 1'b1;
        n = 0;
        while (grant_log.size() < n0 + 5 && n < 60) begin
            step();
            n++;
        end
        keep_all = 1'b0;
        run_until_idle(100);
        check("order_count", W'(grant_log.size() >= n0 + 5), W'(1));
        if (grant_log.size() >= n0 + 5) begin
            for (int k = 0; k < 5; k++)
                check($sformatf("order%0d", k), W'(grant_log[n0+k]), W'(exp_order[k]));
            for (int k = 0; k < 4; k++)
                check($sformatf("spacing%0d", k), W'(acc_log[n0+k+1] - acc_log[n0+k]), W'(4));
        end

        // Response back-pressure with other requests pending.
        rdy_mode = 0;
        post_rand(1);
        repeat (4) step();
        post_rand(0);
        post_rand(2);
        post_rand(3);
        na = acc_log.size();
        repeat (10) step();
        check("stall_no_accept", W'(acc_log.size() - na), W'(0));
        rdy_mode = 1;
        step();
        n = 0;
        while (acc_log.size() == na && n < 10) begin
            step();
            n++;
        end
        check("accept_after_release", W'(last_acc_cyc - last_hs_cyc), W'(1));
        run_until_idle(100);

        // Reset while holding a response.
        rdy_mode = 0;
        post_rand(3);
        repeat (5) step();
        do_reset();
        rdy_mode = 1;
        n0 = grant_log.size();
        post_rand(0);
        run_until_idle(20);
        if (grant_log.size() > n0) check("post_reset_grant", W'(grant_log[n0]), W'(0));
        else check("post_reset_grant_seen", W'(0), W'(1));

        // Random traffic with random back-pressure.
        rand_post = 1'b1;
        rdy_mode  = 2;
        repeat (400) step();
        rand_post = 1'b0;
        rdy_mode  = 1;
        run_until_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 time units");
        $fatal(1);
    end

endmodule
